// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between the EX/MEM stage and a 64-bit word-addressed
//   data memory. Byte-addressed requests of 1/2/4/8 bytes; sub-word stores are
//   done as read-modify-write. Misaligned or out-of-range requests complete
//   with fault and never touch memory.
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   req, op, size,      : request (sampled in IDLE only), 0=load/1=store,
//   sign_ext, addr,     : 00 byte .. 11 double, load extension mode,
//   wdata               : byte address, right-justified store data
//   busy, done, fault   : not-idle, completion pulse, fault flag (with done)
//   rdata               : last non-faulting load result
//   mem_address/data_in : word index and write word to memory
//   mem_read/mem_write  : memory strobes
//   mem_data_out        : combinational memory read data
module mem_access_unit #(
  parameter int n        = 64,
  parameter int log2Size = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         op,
  input  logic [1:0]   size,
  input  logic         sign_ext,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic [n-1:0] rdata,
  output logic [n-1:0] mem_address,
  output logic [n-1:0] mem_data_in,
  output logic         mem_read,
  output logic         mem_write,
  input  logic [n-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t       state_q;
  logic         op_q;
  logic [1:0]   size_q;
  logic         sign_ext_q;
  logic [n-1:0] addr_q;
  logic [n-1:0] wdata_q;
  logic [n-1:0] word_q;
  logic [n-1:0] rdata_q;
  logic         fault_q;

  logic         fault_d;
  logic [n-1:0] rdata_d;
  logic [n-1:0] merge_d;
  logic [5:0]   lane_sh;
  logic [n-1:0] shifted;
  logic [n-1:0] lane_mask;

  // Requests reaching READ/WRITE are aligned, so 8*addr[2:0] is also the
  // correct lane offset for half and word accesses.
  assign lane_sh = {addr_q[2:0], 3'b000};

  always_comb begin
    fault_d = |addr_q[n-1:log2Size+3];
    case (size_q)
      2'b01:   fault_d = fault_d | addr_q[0];
      2'b10:   fault_d = fault_d | (|addr_q[1:0]);
      2'b11:   fault_d = fault_d | (|addr_q[2:0]);
      default: ;
    endcase
  end

  always_comb begin
    shifted = mem_data_out >> lane_sh;
    rdata_d = shifted;
    case (size_q)
      2'b00: rdata_d = sign_ext_q ? {{(n-8){shifted[7]}}, shifted[7:0]}
                                  : {{(n-8){1'b0}}, shifted[7:0]};
      2'b01: rdata_d = sign_ext_q ? {{(n-16){shifted[15]}}, shifted[15:0]}
                                  : {{(n-16){1'b0}}, shifted[15:0]};
      2'b10: rdata_d = sign_ext_q ? {{(n-32){shifted[31]}}, shifted[31:0]}
                                  : {{(n-32){1'b0}}, shifted[31:0]};
      default: rdata_d = shifted;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   lane_mask = {{(n-8){1'b0}}, 8'hFF} << lane_sh;
      2'b01:   lane_mask = {{(n-16){1'b0}}, 16'hFFFF} << lane_sh;
      2'b10:   lane_mask = {{(n-32){1'b0}}, 32'hFFFF_FFFF} << lane_sh;
      default: lane_mask = '1;
    endcase
    merge_d = (word_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      size_q     <= '0;
      sign_ext_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            op_q       <= op;
            size_q     <= size;
            sign_ext_q <= sign_ext;
            addr_q     <= addr;
            wdata_q    <= wdata;
            state_q    <= S_CHECK;
          end
        end
        S_CHECK: begin
          fault_q <= fault_d;
          if (fault_d)                       state_q <= S_DONE;
          else if (!op_q || size_q != 2'b11) state_q <= S_READ;
          else                               state_q <= S_WRITE;
        end
        S_READ: begin
          word_q <= mem_data_out;
          if (!op_q) begin
            rdata_q <= rdata_d;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WRITE;
          end
        end
        S_WRITE: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign fault       = (state_q == S_DONE) & fault_q;
  assign mem_read    = (state_q == S_READ);
  assign mem_write   = (state_q == S_WRITE);
  assign rdata       = rdata_q;
  assign mem_address = {3'b000, addr_q[n-1:3]};
  assign mem_data_in = (state_q != S_WRITE) ? '0
                     : (size_q == 2'b11)    ? wdata_q
                     : merge_d;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        op;
  logic [1:0]  size;
  logic        sign_ext;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        busy, done, fault, mem_read, mem_write;
  logic [63:0] rdata, mem_address, mem_data_in, mem_data_out;

  mem_access_unit #(.n(64), .log2Size(10)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .fault(fault), .rdata(rdata), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [63:0] mem [0:1023];
  int          cyc = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  logic [63:0] last_wr_addr = '0;

  assign mem_data_out = mem_read ? mem[mem_address[9:0]] : '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      mem[mem_address[9:0]] <= mem_data_in;
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_address;
    end
    if (mem_read) rd_count <= rd_count + 1;
  end

  // Scoreboard
  typedef struct {
    logic        fault;
    logic [63:0] rdata;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        check("fault", {63'b0, fault}, {63'b0, e.fault});
        check("rdata", rdata, e.rdata);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %b expected 0", busy);
    end
  endtask

  // Issue one request, queue its expected response, and wait for completion.
  task automatic issue(input logic o, input logic [1:0] sz, input logic se,
                       input logic [63:0] a, input logic [63:0] wd,
                       input int lat, input logic ef, input logic [63:0] erd);
    @(negedge clk);
    wait_idle();
    op = o; size = sz; sign_ext = se; addr = a; wdata = wd; req = 1'b1;
    exp_q.push_back('{ef, erd, cyc + 1 + lat});
    @(negedge clk);
    req = 1'b0;
    // scramble inputs after acceptance
    op = ~o; size = ~sz; sign_ext = ~se; addr = ~a; wdata = ~wd;
    wait_idle();
  endtask

  localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D2 = 64'h0123_4567_FFAB_CDEF;
  localparam logic [63:0] M  = 64'hDEAD_BEEF_5555_CDEF;

  int w0, r0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset = 1'b1; req = 1'b0; op = 1'b0; size = '0; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",  {63'b0, busy}, 64'd0);
    check("reset_done",  {63'b0, done}, 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_strobes", {62'b0, mem_read, mem_write}, 64'd0);
    reset = 1'b0;

    // Doubleword round trip
    w0 = wr_count;
    issue(1'b1, 2'b11, 1'b0, 64'h40, D1, 2, 1'b0, 64'h0);
    check("st64_wr_count", 64'(wr_count - w0), 64'd1);
    check("st64_wr_addr", last_wr_addr, 64'h8);
    issue(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 2, 1'b0, D1);

    // Byte RMW (upper wdata bits must not leak)
    w0 = wr_count;
    issue(1'b1, 2'b00, 1'b0, 64'h43, 64'h1234_56FF, 3, 1'b0, D1);
    check("stb_wr_count", 64'(wr_count - w0), 64'd1);
    issue(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 2, 1'b0, D2);

    // Extension
    issue(1'b0, 2'b00, 1'b1, 64'h43, 64'h0, 2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b0, 2'b00, 1'b0, 64'h43, 64'h0, 2, 1'b0, 64'h0000_0000_0000_00FF);
    issue(1'b0, 2'b01, 1'b1, 64'h46, 64'h0, 2, 1'b0, 64'h0000_0000_0000_0123);

    // Faults
    r0 = rd_count;
    issue(1'b0, 2'b10, 1'b0, 64'h42, 64'h0, 1, 1'b1, 64'h0123);
    check("fault_no_read", 64'(rd_count - r0), 64'd0);
    w0 = wr_count;
    issue(1'b1, 2'b11, 1'b0, 64'h2000, 64'hAAAA, 1, 1'b1, 64'h0123);
    check("fault_no_write", 64'(wr_count - w0), 64'd0);

    // Word and half RMW lanes, word extension
    issue(1'b1, 2'b10, 1'b0, 64'h44, 64'h7777_DEAD_BEEF, 3, 1'b0, 64'h0123);
    issue(1'b1, 2'b01, 1'b0, 64'h42, 64'h9999_5555, 3, 1'b0, 64'h0123);
    issue(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 2, 1'b0, M);
    issue(1'b0, 2'b10, 1'b0, 64'h44, 64'h0, 2, 1'b0, 64'h0000_0000_DEAD_BEEF);
    issue(1'b0, 2'b10, 1'b1, 64'h44, 64'h0, 2, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF);

    // Busy behaviour: req in every busy cycle is ignored; req held through
    // DONE is taken once the unit is back in IDLE.
    @(negedge clk);
    wait_idle();
    w0 = wr_count;
    op = 1'b0; size = 2'b11; sign_ext = 1'b0; addr = 64'h40; req = 1'b1;
    exp_q.push_back('{1'b0, M, cyc + 3});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      op = 1'b1; size = 2'b11; addr = 64'h0; wdata = 64'hBAD0_BAD0; req = 1'b1;
    end
    @(negedge clk);
    op = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 64'h45; req = 1'b1;
    exp_q.push_back('{1'b0, 64'h0000_0000_0000_00BE, cyc + 4});
    repeat (2) @(negedge clk);
    req = 1'b0;
    wait_idle();
    check("busy_no_write", 64'(wr_count - w0), 64'd0);
    check("busy_mem0", mem[0], 64'h0);

    // Reset in READ of a byte store
    @(negedge clk);
    wait_idle();
    w0 = wr_count;
    op = 1'b1; size = 2'b00; addr = 64'h40; wdata = 64'h77; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rst_in_read", {63'b0, mem_read}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_strobes", {61'b0, mem_read, mem_write, done}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_mem_if", mem_address | mem_data_in, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_write", 64'(wr_count - w0), 64'd0);
    check("rst_mem_kept", mem[8], M);
    issue(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 2, 1'b0, M);

    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (exp_q.size() != 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_done: %0d pending expected 0", exp_q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
